multicycle_ctrl_fsm: RTL and testbench
======================================

# multicycle_ctrl_fsm

Main control unit for the multicycle RV32I core. It sequences every instruction through fetch, decode, execute, memory and writeback states. It drives all datapath mux selects and write enables, and produces the 2-bit ALUOp consumed by the ALU decoder that sits directly downstream. Instruction opcodes supported: lw, sw, R-type, I-type ALU, beq, jal.

## Interface
Parameters:
- None. Encodings are fixed in the shared package.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are `clk` (posedge) and `rst`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `op`  in  7  opcode from instruction register (Instr[6:0])
- `Zero`  in  1  ALU zero flag, same cycle as BEQ state
- `PCWrite`  out  1  PC register enable = (Branch & Zero) | PCUpdate
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result
- `MemWrite`  out  1  data memory write enable
- `IRWrite`  out  1  instruction/OldPC register enable
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = RegA
- `ALUSrcB`  out  2  00 = RegB, 01 = ImmExt, 10 = constant 4
- `ALUOp`  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- `RegWrite`  out  1  register file write enable
- `ImmSrc`  out  2  00 = I, 01 = S, 10 = B, 11 = J; combinational from `op`
- `IllegalOp`  out  1  high in DECODE when `op` is unrecognised
- `State`  out  4  current state code, for debug and verification

## Operation
- Moore FSM with a 4-bit state register. All outputs except `PCWrite`, `ImmSrc` and `IllegalOp` are pure functions of state.
- Unlisted outputs are 0 in every state.
- FETCH (0): AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state is DECODE.
- DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00, which precomputes the branch/jump target. Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → FETCH, with IllegalOp=1 for this cycle only
- MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD (3): ResultSrc=00, AdrSrc=1. Next state is MEMWB.
- MEMWB (4): ResultSrc=01, RegWrite=1. Next state is FETCH.
- MEMWRITE (5): ResultSrc=00, AdrSrc=1, MemWrite=1. Next state is FETCH.
- EXECR (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- EXECI (7): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is ALUWB.
- ALUWB (8): ResultSrc=00, RegWrite=1. Next state is FETCH.
- JAL (9): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state is ALUWB.
- BEQ (10): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state is FETCH.
- Unused codes 11–15 → FETCH next cycle. All enables are 0 while in an unused code.
- `op` is sampled only in DECODE and MEMADR. It is don't-care elsewhere.

## Timing
- Next state is registered on posedge `clk`. Outputs settle combinationally within the same cycle.
- While `rst`=1: the state register loads FETCH.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - All other outputs show FETCH values: AdrSrc=0, ResultSrc=10, ALUSrcA=00, ALUSrcB=10, ALUOp=00, IllegalOp=0, State=0.
- First FETCH with live enables is the first cycle with `rst`=0.
- Reset asserted mid-instruction: the state is FETCH on the next edge. No partial writeback or store occurs after the reset edge.
- Instruction latency in cycles (FETCH through last state):
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - jal: 4
  - beq: 3
  - illegal: 2
- `Zero` is used only in BEQ. The branch is taken only when Zero=1 in that cycle. PCWrite must not glitch high in any other state.

## Structure
- Package `riscv_ctrl_pkg`:
  - state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ)
  - ALUOp, ResultSrc, ALUSrcA/B and ImmSrc encodings
- The package is shared with the ALU decoder and datapath.
- One sub-module, `instr_imm_decoder`: combinational `op`→`ImmSrc`. Unknown opcodes give 00.

## Test plan
- Reset: hold `rst` high for 3 cycles with op=0110011. Required: State=0, all write enables 0, ALUSrcB=10. First cycle after release: IRWrite=1 and PCWrite=1.
- lw (op=0000011): state sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01. AdrSrc=1 in state 3.
- sw then R-type back to back:
  - sw gives 0,1,2,5,0, with MemWrite=1 only in state 5.
  - R-type gives 0,1,6,8,0, with ALUOp=10 in state 6.
- beq (op=1100011): with Zero=1 in state 10, PCWrite=1. With Zero=0, PCWrite=0. Sequence is 0,1,10,0. Zero=1 injected in other states never raises PCWrite.
- jal (op=1101111): sequence 0,1,9,8,0. PCWrite=1 in state 9. RegWrite=1 in state 8. ImmSrc=11 throughout.
- Illegal op (0000000) and reset mid-instruction:
  - Illegal op gives IllegalOp=1 in state 1 only, then state 0.
  - Assert `rst` in MEMREAD: next state 0 and no RegWrite pulse.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RV32I control path
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // True for every opcode the control unit knows how to sequence.
    function automatic logic is_known_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/instr_imm_decoder.sv
// rtl/instr_imm_decoder.sv - opcode to immediate-format select
import riscv_ctrl_pkg::*;

module instr_imm_decoder (
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    // Immediate format depends only on opcode; R-type and unknown opcodes fall to I.
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - Moore control FSM for the multicycle RV32I core
import riscv_ctrl_pkg::*;

module multicycle_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_t state;
    state_t next_state;

    logic       pc_update;
    logic       branch;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;

    instr_imm_decoder u_imm_dec (
        .op      (op),
        .imm_src (ImmSrc)
    );

    // State register; reset lands in FETCH so the next instruction starts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing; op matters only in DECODE and MEMADR.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BEQ:       next_state = S_BEQ;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = S_FETCH;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_BEQ:      next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    // Per-state datapath controls; anything not named in a state stays 0.
    always_comb begin
        pc_update    = 1'b0;
        branch       = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_REGB;
        alu_op_s     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                alu_src_a_s  = SRCA_PC;
                alu_src_b_s  = SRCB_FOUR;
                alu_op_s     = ALUOP_ADD;
                result_src_s = RES_ALURESULT;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_ADD;
            end
            S_MEMADR: begin
                alu_src_a_s = SRCA_REGA;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                result_src_s = RES_ALUOUT;
                adr_src_s    = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                result_src_s = RES_ALUOUT;
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_s = SRCA_REGA;
                alu_src_b_s = SRCB_REGB;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a_s = SRCA_REGA;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src_s = RES_ALUOUT;
                reg_write_s  = 1'b1;
            end
            S_JAL: begin
                alu_src_a_s  = SRCA_OLDPC;
                alu_src_b_s  = SRCB_FOUR;
                alu_op_s     = ALUOP_ADD;
                result_src_s = RES_ALUOUT;
                pc_update    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s  = SRCA_REGA;
                alu_src_b_s  = SRCB_REGB;
                alu_op_s     = ALUOP_SUB;
                result_src_s = RES_ALUOUT;
                branch       = 1'b1;
            end
            default: begin
                pc_update = 1'b0;
            end
        endcase
    end

    // Output stage: while rst is high, show FETCH selects with every write enable held off.
    always_comb begin
        PCWrite   = (branch & Zero) | pc_update;
        AdrSrc    = adr_src_s;
        MemWrite  = mem_write_s;
        IRWrite   = ir_write_s;
        RegWrite  = reg_write_s;
        ResultSrc = result_src_s;
        ALUSrcA   = alu_src_a_s;
        ALUSrcB   = alu_src_b_s;
        ALUOp     = alu_op_s;
        IllegalOp = (state == S_DECODE) && !is_known_op(op);
        State     = state;
        if (rst) begin
            PCWrite   = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = RES_ALURESULT;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ALUOp     = ALUOP_ADD;
            IllegalOp = 1'b0;
            State     = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - scoreboard bench for the multicycle control FSM
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic       rw;
        logic [1:0] imm;
        logic       ill;
    } rec_t;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];

    multicycle_ctrl_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .Zero      (Zero),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .RegWrite  (RegWrite),
        .ImmSrc    (ImmSrc),
        .IllegalOp (IllegalOp),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic known(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
    endfunction

    // Reference output table, written directly from the state descriptions.
    function automatic rec_t exp_rec(input int s, input logic [6:0] o, input logic z);
        rec_t r;
        r = '0;
        r.st  = s[3:0];
        r.imm = imm_of(o);
        case (s)
            0:  begin r.irw = 1; r.sb = 2'b10; r.rs = 2'b10; r.pcw = 1; end
            1:  begin r.sa = 2'b01; r.sb = 2'b01; r.ill = !known(o); end
            2:  begin r.sa = 2'b10; r.sb = 2'b01; end
            3:  begin r.adr = 1; end
            4:  begin r.rs = 2'b01; r.rw = 1; end
            5:  begin r.adr = 1; r.memw = 1; end
            6:  begin r.sa = 2'b10; r.aop = 2'b10; end
            7:  begin r.sa = 2'b10; r.sb = 2'b01; r.aop = 2'b10; end
            8:  begin r.rw = 1; end
            9:  begin r.sa = 2'b01; r.sb = 2'b10; r.pcw = 1; end
            10: begin r.sa = 2'b10; r.aop = 2'b01; r.pcw = z; end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic rec_t reset_rec(input logic [6:0] o);
        rec_t r;
        r = '0;
        r.sb  = 2'b10;
        r.rs  = 2'b10;
        r.imm = imm_of(o);
        return r;
    endfunction

    function automatic rec_t sample();
        rec_t r;
        r.st = State; r.pcw = PCWrite; r.adr = AdrSrc; r.memw = MemWrite;
        r.irw = IRWrite; r.rs = ResultSrc; r.sa = ALUSrcA; r.sb = ALUSrcB;
        r.aop = ALUOp; r.rw = RegWrite; r.imm = ImmSrc; r.ill = IllegalOp;
        return r;
    endfunction

    // Drive one instruction from FETCH; rst_at >= 0 asserts rst in that step and stops.
    task automatic drive_instr(input logic [6:0] o, input logic z_beq,
                               input logic z_other, input int rst_at);
        int seq[$];
        seq = {0, 1};
        case (o)
            7'b0000011: seq = {0, 1, 2, 3, 4};
            7'b0100011: seq = {0, 1, 2, 5};
            7'b0110011: seq = {0, 1, 6, 8};
            7'b0010011: seq = {0, 1, 7, 8};
            7'b1101111: seq = {0, 1, 9, 8};
            7'b1100011: seq = {0, 1, 10};
            default:    seq = {0, 1};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            @(posedge clk);
            #2;
            op   = o;
            Zero = (seq[i] == 10) ? z_beq : z_other;
            if (i == rst_at) begin
                rst = 1'b1;
                exp_q.push_back(reset_rec(o));
            end else begin
                rst = 1'b0;
                exp_q.push_back(exp_rec(seq[i], o, Zero));
            end
            #2;
            obs_q.push_back(sample());
            if (i == rst_at) break;
        end
    endtask

    task automatic test_reset();
        rec_t e, a;
        op   = 7'b0110011;
        Zero = 1'b0;
        rst  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            exp_q.push_back(reset_rec(op));
            #2;
            obs_q.push_back(sample());
        end
        drive_instr(7'b0110011, 1'b0, 1'b0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = obs_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL reset: got %h required %h", a, e);
            end
        end
    endtask

    task automatic test_lw();
        rec_t e, a;
        drive_instr(7'b0000011, 1'b0, 1'b1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = obs_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL lw state %0d: got %h required %h", e.st, a, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t e, a;
        drive_instr(7'b0100011, 1'b0, 1'b0, -1);
        drive_instr(7'b0110011, 1'b0, 1'b0, -1);
        drive_instr(7'b0010011, 1'b0, 1'b1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = obs_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL b2b state %0d: got %h required %h", e.st, a, e);
            end
        end
    endtask

    task automatic test_beq();
        rec_t e, a;
        drive_instr(7'b1100011, 1'b1, 1'b0, -1);
        drive_instr(7'b1100011, 1'b0, 1'b1, -1);
        drive_instr(7'b1100011, 1'b1, 1'b1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = obs_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL beq state %0d: got %h required %h", e.st, a, e);
            end
        end
    endtask

    task automatic test_jal();
        rec_t e, a;
        drive_instr(7'b1101111, 1'b0, 1'b1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = obs_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL jal state %0d: got %h required %h", e.st, a, e);
            end
        end
    endtask

    task automatic test_illegal_and_mid_reset();
        rec_t e, a;
        drive_instr(7'b0000000, 1'b0, 1'b0, -1);
        drive_instr(7'b1111111, 1'b0, 1'b1, -1);
        drive_instr(7'b0000011, 1'b0, 1'b0, 3);
        drive_instr(7'b0100011, 1'b0, 1'b0, 3);
        drive_instr(7'b0000011, 1'b0, 1'b0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = obs_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL illegal/midreset state %0d: got %h required %h", e.st, a, e);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        op   = 7'b0110011;
        Zero = 1'b0;
        test_reset();
        test_lw();
        test_back_to_back();
        test_beq();
        test_jal();
        test_illegal_and_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
